conv_scale_ctrl: RTL and testbench

CONV_SCALE_CTRL -- requirements
Module: conv_scale_ctrl

---
 rtl/conv_scale_ctrl_pkg.sv | 19 +
 rtl/conv_scale_bank.sv | 36 +++
 rtl/conv_scale_ctrl.sv | 160 ++++++++++++++++
 tb/tb_conv_scale_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_scale_ctrl_pkg.sv
// Shared types and defaults for the convolution scale controller.
// Holds the FSM state encoding and the default pipeline/bank sizes.
package conv_scale_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int MULT_LATENCY_DEF = 6;
  localparam int SCALE_DEPTH_DEF  = 64;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_scale_bank.sv
// Scale word storage: one row per channel group, written a word at a time,
// read a full group vector at a time (same-cycle writes are forwarded).
module conv_scale_bank
  import conv_scale_ctrl_pkg::*;
#(
  parameter int CHANNEL_OUT_NUM = 8,
  parameter int WIDTH_DATA_ADD  = 32,
  parameter int SCALE_DEPTH     = SCALE_DEPTH_DEF,
  localparam int GRP_W = clog2_min1(SCALE_DEPTH),
  localparam int CH_W  = clog2_min1(CHANNEL_OUT_NUM),
  localparam int VEC_W = WIDTH_DATA_ADD * CHANNEL_OUT_NUM
) (
  input  logic                      clk,
  input  logic                      wr_en,
  input  logic [GRP_W-1:0]          wr_grp,
  input  logic [CH_W-1:0]           wr_ch,
  input  logic [WIDTH_DATA_ADD-1:0] wr_data,
  input  logic [GRP_W-1:0]          rd_grp,
  output logic [VEC_W-1:0]          rd_data
);

  logic [VEC_W-1:0] mem [SCALE_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_grp][int'(wr_ch)*WIDTH_DATA_ADD +: WIDTH_DATA_ADD] <= wr_data;
  end

  // Forwarding lets a one-group job present its final word on RUN entry.
  always_comb begin
    rd_data = mem[rd_grp];
    if (wr_en && (wr_grp == rd_grp))
      rd_data[int'(wr_ch)*WIDTH_DATA_ADD +: WIDTH_DATA_ADD] = wr_data;
  end

endmodule

// File: rtl/conv_scale_ctrl.sv
// Loads per-group scale vectors, then steps them in lock-step with data beats
// into a fixed-latency multiplier array. Optional checker: SCALE_PROTOCOL_CHK_EN.
module conv_scale_ctrl
  import conv_scale_ctrl_pkg::*;
#(
  parameter int CHANNEL_OUT_NUM = 8,
  parameter int WIDTH_DATA_ADD  = 32,
  parameter int MULT_LATENCY    = MULT_LATENCY_DEF,
  parameter int SCALE_DEPTH     = SCALE_DEPTH_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      Start,
  input  logic [6:0]                                Cfg_Group_Num,
  input  logic [15:0]                               Cfg_Beats,
  input  logic                                      Scale_In_Valid,
  output logic                                      Scale_In_Ready,
  input  logic [WIDTH_DATA_ADD-1:0]                 Scale_In_Data,
  input  logic                                      S_Valid,
  output logic                                      S_Ready,
  output logic [WIDTH_DATA_ADD*CHANNEL_OUT_NUM-1:0] Scale_Data_In,
  output logic                                      Mult_Valid_Out,
  output logic                                      Last_Out,
  output logic                                      Busy,
  output logic                                      Done,
  output logic                                      Err
);

  localparam int VEC_W = WIDTH_DATA_ADD * CHANNEL_OUT_NUM;
  localparam int GRP_W = clog2_min1(SCALE_DEPTH);
  localparam int CH_W  = clog2_min1(CHANNEL_OUT_NUM);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNEL_OUT_NUM - 1);

  state_t                  state, state_nxt;
  logic [GRP_W-1:0]        grp_last, ld_grp, grp_ptr, rd_grp;
  logic [CH_W-1:0]         ld_ch;
  logic [15:0]             beat_last, beat_cnt;
  logic                    gap, done_q;
  logic [MULT_LATENCY-1:0] vld_p, last_p;
  logic [VEC_W-1:0]        scale_vec, bank_rd;
  logic                    cfg_ok, start_ok, load_acc, load_end;
  logic                    beat_acc, beat_wrap, grp_end, job_last;

  assign cfg_ok    = (Cfg_Group_Num != 7'd0) && (int'(Cfg_Group_Num) <= SCALE_DEPTH)
                     && (Cfg_Beats != 16'd0);
  assign start_ok  = Start && cfg_ok && (state == ST_IDLE);
  assign load_acc  = Scale_In_Valid && Scale_In_Ready;
  assign load_end  = load_acc && (ld_grp == grp_last) && (ld_ch == CH_LAST);
  assign beat_acc  = S_Valid && S_Ready;
  assign beat_wrap = beat_acc && (beat_cnt == beat_last);
  assign grp_end   = (grp_ptr == grp_last);
  assign job_last  = beat_wrap && grp_end;
  assign rd_grp    = (state == ST_LOAD) ? '0 : grp_ptr + GRP_W'(1);

  conv_scale_bank #(
    .CHANNEL_OUT_NUM (CHANNEL_OUT_NUM),
    .WIDTH_DATA_ADD  (WIDTH_DATA_ADD),
    .SCALE_DEPTH     (SCALE_DEPTH)
  ) u_bank (
    .clk     (clk),
    .wr_en   (load_acc),
    .wr_grp  (ld_grp),
    .wr_ch   (ld_ch),
    .wr_data (Scale_In_Data),
    .rd_grp  (rd_grp),
    .rd_data (bank_rd)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_LOAD;
      ST_LOAD:  if (load_end) state_nxt = ST_RUN;
      ST_RUN:   if (job_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_p[MULT_LATENCY-1]) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      grp_last  <= '0;
      beat_last <= '0;
      ld_grp    <= '0;
      ld_ch     <= '0;
      grp_ptr   <= '0;
      beat_cnt  <= '0;
      gap       <= 1'b0;
      scale_vec <= '0;
      vld_p     <= '0;
      last_p    <= '0;
      done_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      gap   <= 1'b0;
      if (start_ok) begin
        grp_last  <= GRP_W'(Cfg_Group_Num - 7'd1);
        beat_last <= Cfg_Beats - 16'd1;
        ld_grp    <= '0;
        ld_ch     <= '0;
        grp_ptr   <= '0;
        beat_cnt  <= '0;
      end
      if (load_acc) begin
        if (ld_ch == CH_LAST) begin
          ld_ch  <= '0;
          ld_grp <= ld_grp + GRP_W'(1);
        end else begin
          ld_ch <= ld_ch + CH_W'(1);
        end
      end
      if (load_end)
        scale_vec <= bank_rd;
      // The ready gap after a wrap keeps beats off the outgoing vector.
      if (beat_acc) begin
        if (beat_wrap) begin
          beat_cnt <= '0;
          if (!grp_end) begin
            grp_ptr   <= grp_ptr + GRP_W'(1);
            scale_vec <= bank_rd;
            gap       <= 1'b1;
          end
        end else begin
          beat_cnt <= beat_cnt + 16'd1;
        end
      end
      // Stage boundary: beat accept -> product valid, MULT_LATENCY deep.
      vld_p  <= (vld_p << 1) | MULT_LATENCY'(beat_acc);
      last_p <= (last_p << 1) | MULT_LATENCY'(job_last);
      done_q <= (state == ST_DRAIN) && last_p[MULT_LATENCY-1];
    end
  end

  assign Scale_In_Ready = (state == ST_LOAD);
  assign S_Ready        = (state == ST_RUN) && !gap;
  assign Scale_Data_In  = scale_vec;
  assign Mult_Valid_Out = vld_p[MULT_LATENCY-1];
  assign Last_Out       = last_p[MULT_LATENCY-1];
  assign Busy           = (state != ST_IDLE);
  assign Done           = done_q;

`ifdef SCALE_PROTOCOL_CHK_EN
  logic err_q, proto_bad;

  assign proto_bad = (Scale_In_Valid && (state != ST_LOAD))
                   || (S_Valid && ((state == ST_LOAD) || (state == ST_DRAIN)))
                   || (Start && !start_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_q | proto_bad;
  end

  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_scale_ctrl.sv
// Scoreboard bench for conv_scale_ctrl: driver pushes expected products,
// a negedge monitor pops them against Mult_Valid_Out/Last_Out/Done.
module tb_conv_scale_ctrl;

  localparam int C     = 8;
  localparam int W     = 32;
  localparam int L     = 6;
  localparam int VEC_W = W * C;

`ifdef SCALE_PROTOCOL_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    int due;
    bit last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             Start;
  logic [6:0]       Cfg_Group_Num;
  logic [15:0]      Cfg_Beats;
  logic             Scale_In_Valid;
  logic             Scale_In_Ready;
  logic [W-1:0]     Scale_In_Data;
  logic             S_Valid;
  logic             S_Ready;
  logic [VEC_W-1:0] Scale_Data_In;
  logic             Mult_Valid_Out;
  logic             Last_Out;
  logic             Busy;
  logic             Done;
  logic             Err;

  int       n_checks = 0;
  int       n_pass   = 0;
  int       cyc      = 0;
  bit       mon_en   = 1'b0;
  bit       exp_err  = 1'b0;
  exp_t     exp_q [$];
  int       done_q [$];
  bit [W-1:0] words [$];

  conv_scale_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .Start          (Start),
    .Cfg_Group_Num  (Cfg_Group_Num),
    .Cfg_Beats      (Cfg_Beats),
    .Scale_In_Valid (Scale_In_Valid),
    .Scale_In_Ready (Scale_In_Ready),
    .Scale_In_Data  (Scale_In_Data),
    .S_Valid        (S_Valid),
    .S_Ready        (S_Ready),
    .Scale_Data_In  (Scale_Data_In),
    .Mult_Valid_Out (Mult_Valid_Out),
    .Last_Out       (Last_Out),
    .Busy           (Busy),
    .Done           (Done),
    .Err            (Err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [VEC_W-1:0] act,
                       input logic [VEC_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Group g's vector: channel c holds load word g*C+c in bits [c*W +: W].
  function automatic logic [VEC_W-1:0] exp_vec(input int g);
    logic [VEC_W-1:0] v = '0;
    for (int c = 0; c < C; c++) v[c*W +: W] = words[g*C + c];
    return v;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check("mult_valid_out", Mult_Valid_Out, 1);
        check("last_out", Last_Out, exp_q[0].last);
        exp_q.delete(0);
      end else begin
        check("mult_valid_out_idle", Mult_Valid_Out, 0);
        check("last_out_idle", Last_Out, 0);
      end
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        check("done", Done, 1);
        done_q.delete(0);
      end else begin
        check("done_idle", Done, 0);
      end
    end
  end

  // load_mode: 0 continuous, 1 every other cycle, 2 random. sv_mode: 0 continuous, 1 random.
  task automatic run_job(input int g, input int b, input int load_mode, input int sv_mode,
                         input bit seq_words, input bit mid_start, input bit abort);
    int   total, k, guard, acc, grp, beat, iter;
    bit   tog, v, sv, gap, ng;
    exp_t e;
    total = g * b;
    words.delete();
    for (int i = 0; i < g*C; i++) words.push_back(seq_words ? 32'(i + 1) : $urandom);

    Start = 1'b1; Cfg_Group_Num = 7'(g); Cfg_Beats = 16'(b);
    @(negedge clk);
    check("busy_before_start", Busy, 0);
    @(posedge clk); #1;
    Start = 1'b0;

    k = 0; tog = 1'b1; guard = 0;
    while (k < g*C && guard < 8*g*C + 20) begin
      case (load_mode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = ($urandom_range(0, 1) == 1);
      endcase
      Scale_In_Valid = v;
      Scale_In_Data  = words[k];
      @(negedge clk);
      check("scale_in_ready_load", Scale_In_Ready, 1);
      check("s_ready_load", S_Ready, 0);
      check("busy_load", Busy, 1);
      @(posedge clk); #1;
      if (v) k++;
      tog = !tog;
      guard++;
    end
    Scale_In_Valid = 1'b0;
    check("load_complete", k, g*C);

    check("scale_vec_run_entry", Scale_Data_In, exp_vec(0));
    acc = 0; grp = 0; beat = 0; gap = 1'b0; iter = 0; guard = 0;
    while (acc < total && guard < 8*total + 20) begin
      Start = mid_start && (iter == 1);
      if (Start) begin
        Cfg_Group_Num = 7'd2;
        Cfg_Beats     = 16'd1;
      end
      sv = (sv_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      S_Valid = sv;
      @(negedge clk);
      check("s_ready_run", S_Ready, !gap);
      ng = 1'b0;
      if (sv && !gap) begin
        check("scale_vec_beat", Scale_Data_In, exp_vec(grp));
        e.due  = cyc + L;
        e.last = (acc == total - 1);
        exp_q.push_back(e);
        if (e.last) done_q.push_back(cyc + L + 1);
        acc++;
        beat++;
        if (beat == b) begin
          beat = 0;
          if (grp < g - 1) begin
            grp++;
            ng = 1'b1;
          end
        end
      end
      gap = ng;
      @(posedge clk); #1;
      iter++;
      guard++;
    end
    S_Valid = 1'b0;
    Start   = 1'b0;
    check("beats_accepted", acc, total);
    if (mid_start) exp_err = CHK;

    if (abort) begin
      guard = 0;
      while (exp_q.size() > 3 && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      rst = 1'b0;
      exp_q.delete();
      done_q.delete();
      exp_err = 1'b0;
      @(negedge clk);
      check("busy_in_reset", Busy, 0);
      check("err_in_reset", Err, 0);
      check("scale_vec_in_reset", Scale_Data_In, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check("busy_after_abort", Busy, 0);
    end else begin
      guard = 0;
      while ((exp_q.size() > 0 || done_q.size() > 0) && guard < L + 20) begin
        @(posedge clk); #1;
        guard++;
      end
      check("drain_complete", exp_q.size() + done_q.size(), 0);
      @(negedge clk);
      check("busy_after_done", Busy, 0);
      check("s_ready_idle", S_Ready, 0);
      check("err_after_job", Err, exp_err);
      @(posedge clk); #1;
    end
  endtask

  task automatic bad_start(input int g, input int b);
    Start = 1'b1; Cfg_Group_Num = 7'(g); Cfg_Beats = 16'(b);
    @(posedge clk); #1;
    Start = 1'b0;
    exp_err = CHK;
    @(negedge clk);
    check("busy_bad_start", Busy, 0);
    check("scale_in_ready_bad_start", Scale_In_Ready, 0);
    check("err_bad_start", Err, exp_err);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; Start = 1'b0; Cfg_Group_Num = '0; Cfg_Beats = '0;
    Scale_In_Valid = 1'b0; Scale_In_Data = '0; S_Valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", Busy, 0);
    check("rst_s_ready", S_Ready, 0);
    check("rst_scale_in_ready", Scale_In_Ready, 0);
    check("rst_mult_valid", Mult_Valid_Out, 0);
    check("rst_last", Last_Out, 0);
    check("rst_done", Done, 0);
    check("rst_err", Err, 0);
    check("rst_scale_vec", Scale_Data_In, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_job(1, 4, 0, 0, 1'b1, 1'b0, 1'b0);
    run_job(3, 2, 0, 0, 1'b0, 1'b0, 1'b0);
    run_job(1, 3, 1, 0, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 6; j++)
      run_job(int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), 2, 1, 1'b0, 1'b0, 1'b0);
    run_job(64, 1, 0, 1, 1'b0, 1'b0, 1'b0);

    bad_start(0, 4);
    bad_start(65, 2);
    bad_start(2, 0);
    run_job(2, 3, 0, 1, 1'b0, 1'b1, 1'b0);

    run_job(1, 4, 0, 0, 1'b0, 1'b0, 1'b1);
    run_job(2, 2, 2, 1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
